mod_led_fx: RTL and testbench
=============================

MOD_LED_FX -- requirements
Module: mod_led_fx

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single system clock; bus writes on negedge, all other state on posedge.
REQ-002 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The module SHALL have port ie, input, 1 bit: instruction-bus select.
REQ-004 The module SHALL have port de, input, 1 bit: data-bus select.
REQ-005 The module SHALL have port iaddr, input, 32 bits: instruction address, unused.
REQ-006 The module SHALL have port daddr, input, 32 bits: data address; only daddr[3:2] decoded.
REQ-007 The module SHALL have port drw, input, 1 bit: data write strobe (1 = write).
REQ-008 The module SHALL have port din, input, 32 bits: write data.
REQ-009 The module SHALL have port iout, output, 32 bits: instruction read data.
REQ-010 The module SHALL have port dout, output, 32 bits: data read data.
REQ-011 The module SHALL have port leds_in, input, 8 bits: LED pattern from the LED register module.
REQ-012 The module SHALL have port led_pins, output, 8 bits: registered drive to board LEDs.

Function
REQ-013 iout SHALL be 32'h00000000 when ie=1 and high-Z otherwise.
REQ-014 dout SHALL carry the register selected by daddr[3:2] when de=1 and high-Z otherwise.
REQ-015 Register map SHALL be: 0 CTRL {30'b0, blink_en, fx_en}; 1 DUTY {24'b0, duty_pend}; 2 PERIOD {8'b0, period[23:0]}; 3 STATUS read-only {16'b0, leds_in, 6'b0, pwm_on, phase}.
REQ-016 On negedge clk with de=1, drw=1, rst=0, the module SHALL write din into the selected register; writes to STATUS SHALL be ignored.
REQ-017 pwm_cnt (8 bits) SHALL increment every posedge and wrap 255->0.
REQ-018 duty_act SHALL load from duty_pend only on the posedge where pwm_cnt=255, so there are no mid-period glitches.
REQ-019 pwm_on SHALL be 1 when duty_act=8'hFF or pwm_cnt<duty_act, and 0 otherwise; duty_act=0 SHALL give constant off.
REQ-020 blink_cnt (24 bits) SHALL increment every posedge while period!=0.
REQ-021 When blink_cnt>=period-1, blink_cnt SHALL clear to 0 and phase SHALL toggle on that same edge.
REQ-022 With period=0, blink_cnt SHALL hold at 0 and phase SHALL hold at 1.
REQ-023 A write to PERIOD SHALL clear blink_cnt to 0 and set phase to 1 on the next posedge; this takes priority over the wrap in REQ-021.
REQ-024 The gate signal SHALL be pwm_on AND (blink_en ? phase : 1).
REQ-025 On each posedge, led_pins SHALL register fx_en ? (leds_in AND {8{gate}}) : leds_in, giving one posedge of latency from leds_in or gate changes.
REQ-026 With fx_en=0, led_pins SHALL follow leds_in regardless of DUTY, PERIOD, or blink_en.
REQ-027 A simultaneous DUTY write and pwm_cnt=255 wrap SHALL use the new duty_pend value, since the write on negedge precedes the posedge load.

Reset
REQ-028 While rst=1, the module SHALL asynchronously force CTRL=0, duty_pend=duty_act=8'hFF, period=0, pwm_cnt=0, blink_cnt=0, phase=1, led_pins=8'h00.
REQ-029 Bus writes SHALL be blocked while rst=1.
REQ-030 Reset asserted mid-operation SHALL abandon the PWM and blink periods in progress.
REQ-031 After rst deasserts, the first posedge SHALL drive led_pins=leds_in, since fx_en=0.

Verification
REQ-032 Reset then leds_in=8'hA5, no writes -> led_pins=8'hA5 one posedge after reset release; dout of STATUS={16'b0,8'hA5,8'h03}.
REQ-033 CTRL=1, DUTY=8'h40, leds_in=8'hFF -> from the first pwm_cnt wrap onward, led_pins=8'hFF for exactly 64 of every 256 clocks; DUTY=0 -> constant 8'h00; DUTY=8'hFF -> constant 8'hFF.
REQ-034 CTRL=3, DUTY=8'hFF, PERIOD=10, leds_in=8'h0F -> led_pins alternates 8'h0F/8'h00 every 10 clocks, starting with 8'h0F; STATUS bit0 toggles with it.
REQ-035 Write DUTY=8'h80 while pwm_cnt=100 with old duty 8'h10 -> duty 8'h10 persists until pwm_cnt=255, then high time becomes 128 clocks; DUTY readback=8'h80 immediately.
REQ-036 Mid-blink (blink_cnt=7, period=10), write PERIOD=4 -> blink_cnt restarts at 0, phase=1, toggles after 4 clocks; assert rst mid-PWM -> led_pins=8'h00 immediately, without waiting for a clock edge.
REQ-037 de=0 and ie=0 -> dout and iout both high-Z; ie=1 -> iout=32'h0; de=1, drw=1 with daddr[3:2]=3 -> all registers unchanged.

Source files
------------

// File: rtl/mod_led_fx.sv
// LED effects peripheral: PWM dimming and slow blink gating applied to an LED
// pattern. Bus registers are written on negedge clk; all effect state advances on posedge.
module mod_led_fx (
  input  logic        clk,
  input  logic        rst,
  input  logic        ie,
  input  logic        de,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic        drw,
  input  logic [31:0] din,
  output logic [31:0] iout,
  output logic [31:0] dout,
  input  logic [7:0]  leds_in,
  output logic [7:0]  led_pins
);

  logic        fx_en;
  logic        blink_en;
  logic [7:0]  duty_pend;
  logic [23:0] period;
  logic        period_tgl;

  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_act;
  logic [23:0] blink_cnt;
  logic        phase;
  logic        period_seen;

  logic        pwm_on;
  logic        gate;
  logic        period_pend;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{iaddr, daddr[31:4], daddr[1:0], din[31:24]};

  // A PERIOD write flips period_tgl on negedge; the posedge side sees the
  // mismatch with period_seen as a one-shot restart request for the blink timer.
  assign period_pend = period_tgl ^ period_seen;

  assign pwm_on = (duty_act == 8'hFF) || (pwm_cnt < duty_act);
  assign gate   = pwm_on & (blink_en ? phase : 1'b1);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      fx_en      <= 1'b0;
      blink_en   <= 1'b0;
      duty_pend  <= 8'hFF;
      period     <= 24'd0;
      period_tgl <= 1'b0;
    end else if (de && drw) begin
      case (daddr[3:2])
        2'd0: {blink_en, fx_en} <= din[1:0];
        2'd1: duty_pend <= din[7:0];
        2'd2: begin
          period     <= din[23:0];
          period_tgl <= ~period_tgl;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt     <= 8'd0;
      duty_act    <= 8'hFF;
      blink_cnt   <= 24'd0;
      phase       <= 1'b1;
      period_seen <= 1'b0;
      led_pins    <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      // Duty only changes at the period boundary so a period never glitches.
      if (pwm_cnt == 8'hFF) duty_act <= duty_pend;

      if (period_pend) begin
        blink_cnt   <= 24'd0;
        phase       <= 1'b1;
        period_seen <= period_tgl;
      end else if (period == 24'd0) begin
        blink_cnt <= 24'd0;
        phase     <= 1'b1;
      end else if (blink_cnt >= period - 24'd1) begin
        blink_cnt <= 24'd0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 24'd1;
      end

      led_pins <= fx_en ? (leds_in & {8{gate}}) : leds_in;
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (daddr[3:2])
      2'd0: rd_data = {30'b0, blink_en, fx_en};
      2'd1: rd_data = {24'b0, duty_pend};
      2'd2: rd_data = {8'b0, period};
      default: rd_data = {16'b0, leds_in, 6'b0, pwm_on, phase};
    endcase
  end

  assign iout = ie ? 32'h0 : 32'hzzzz_zzzz;
  assign dout = de ? rd_data : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_mod_led_fx.sv
// Bench for mod_led_fx: reference model works from edge counts since reset and
// since the last blink restart rather than from mirrored counters.
module tb_mod_led_fx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ie = 1'b0;
  logic        de = 1'b0;
  logic [31:0] iaddr = 32'h0;
  logic [31:0] daddr = 32'h0;
  logic        drw = 1'b0;
  logic [31:0] din = 32'h0;
  logic [7:0]  leds_in = 8'h0;
  wire  [31:0] iout;
  wire  [31:0] dout;
  wire  [7:0]  led_pins;

  int checks = 0;
  int errors = 0;

  mod_led_fx dut (
    .clk(clk), .rst(rst), .ie(ie), .de(de), .iaddr(iaddr), .daddr(daddr),
    .drw(drw), .din(din), .iout(iout), .dout(dout), .leds_in(leds_in),
    .led_pins(led_pins)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_fx, m_ben;
  logic [7:0]  m_duty_pend, m_duty_act;
  logic [23:0] m_period, m_bper;
  int          m_t, m_pstart;
  bit          m_pend;
  logic [7:0]  m_exp;

  task automatic model_reset();
    m_fx = 0; m_ben = 0; m_duty_pend = 8'hFF; m_duty_act = 8'hFF;
    m_period = 0; m_bper = 0; m_t = 0; m_pstart = 0; m_pend = 0; m_exp = 8'h00;
  endtask

  // Phase held before edge number e: 1 for the first bper edges after a restart.
  function automatic bit m_phase(int e);
    if (m_bper == 24'd0) return 1'b1;
    return 1'b1 ^ 1'(((e - 1 - m_pstart) / int'(m_bper)) & 1);
  endfunction

  function automatic bit m_pwm(int e);
    return (m_duty_act == 8'hFF) || ((e % 256) < int'(m_duty_act));
  endfunction

  task automatic model_negedge();
    if (!rst && de && drw) begin
      case (daddr[3:2])
        2'd0: begin m_fx = din[0]; m_ben = din[1]; end
        2'd1: m_duty_pend = din[7:0];
        2'd2: begin m_period = din[23:0]; m_pend = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic model_posedge();
    bit g;
    g = m_pwm(m_t) & (m_ben ? m_phase(m_t) : 1'b1);
    m_exp = m_fx ? (leds_in & {8{g}}) : leds_in;
    if (m_t % 256 == 255) m_duty_act = m_duty_pend;
    if (m_pend) begin m_bper = m_period; m_pstart = m_t; m_pend = 0; end
    m_t++;
  endtask

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0: return {30'b0, m_ben, m_fx};
      2'd1: return {24'b0, m_duty_pend};
      2'd2: return {8'b0, m_period};
      default: return {16'b0, leds_in, 6'b0, m_pwm(m_t), m_phase(m_t)};
    endcase
  endfunction

  // ---------------- checking and drivers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_negedge();
    @(posedge clk);
    model_posedge();
    #1 check("led_pins", {24'b0, led_pins}, {24'b0, m_exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    de = 1; drw = 1; daddr = {28'b0, a, 2'b0}; din = d;
    cycle();
    de = 0; drw = 0;
  endtask

  task automatic rd_check(input logic [1:0] a);
    de = 1; drw = 0; daddr = {28'b0, a, 2'b0};
    #1 check("dout_reg", dout, model_reg(a));
    de = 0;
  endtask

  task automatic rd_lit(input string name, input logic [1:0] a, input logic [31:0] exp);
    de = 1; drw = 0; daddr = {28'b0, a, 2'b0};
    #1 check(name, dout, exp);
    de = 0;
  endtask

  task automatic do_reset();
    de = 0; drw = 0;
    rst = 1;
    #1 check("rst_async_led", {24'b0, led_pins}, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("rst_hold_led", {24'b0, led_pins}, 32'h0);
    rd_lit("rst_ctrl", 2'd0, 32'h0);
    rd_lit("rst_duty", 2'd1, 32'h0000_00FF);
    rd_lit("rst_period", 2'd2, 32'h0);
    rst = 0;
  endtask

  task automatic align_wrap();
    while (m_t < 256 || (m_t % 256) != 0) cycle();
  endtask

  task automatic count_ff(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      if (led_pins == 8'hFF) cnt++;
    end
  endtask

  initial begin
    int cnt;
    model_reset();
    #2;
    do_reset();

    // Pass-through after reset and STATUS readback
    leds_in = 8'hA5;
    cycle();
    check("first_edge_led", {24'b0, led_pins}, 32'h0000_00A5);
    rd_lit("status_a5", 2'd3, 32'h0000_A503);

    // Bus select behaviour and ignored STATUS write
    ie = 1;
    #1 check("iout_zero", iout, 32'h0);
    ie = 0;
    wr(2'd3, 32'hFFFF_FFFF);
    rd_lit("ctrl_after_status_wr", 2'd0, 32'h0);
    rd_lit("duty_after_status_wr", 2'd1, 32'h0000_00FF);
    rd_lit("period_after_status_wr", 2'd2, 32'h0);

    // PWM duty 0x40 / 0x00 / 0xFF
    leds_in = 8'hFF;
    wr(2'd0, 32'h1);
    wr(2'd1, 32'h40);
    align_wrap();
    count_ff(256, cnt);
    check("duty40_high", cnt, 64);
    wr(2'd1, 32'h00);
    align_wrap();
    count_ff(256, cnt);
    check("duty00_high", cnt, 0);
    wr(2'd1, 32'hFF);
    align_wrap();
    count_ff(256, cnt);
    check("dutyFF_high", cnt, 256);

    // Blink with period 10
    do_reset();
    leds_in = 8'h0F;
    wr(2'd0, 32'h3);
    wr(2'd2, 32'd10);
    for (int i = 0; i < 40; i++) begin
      cycle();
      check("blink10", {24'b0, led_pins}, ((i / 10) % 2 == 0) ? 32'h0F : 32'h00);
      if (i == 4)  rd_lit("status_ph1", 2'd3, 32'h0000_0F03);
      if (i == 14) rd_lit("status_ph0", 2'd3, 32'h0000_0F02);
    end

    // Duty change mid-period takes effect at the wrap
    do_reset();
    leds_in = 8'hFF;
    wr(2'd0, 32'h1);
    wr(2'd1, 32'h10);
    align_wrap();
    while ((m_t % 256) != 100) cycle();
    wr(2'd1, 32'h80);
    rd_lit("duty_readback", 2'd1, 32'h0000_0080);
    cnt = 0;
    while ((m_t % 256) != 0) begin
      cycle();
      if (led_pins == 8'hFF) cnt++;
    end
    check("old_duty_tail", cnt, 0);
    count_ff(256, cnt);
    check("new_duty_high", cnt, 128);

    // Period rewrite mid-blink restarts the timer
    do_reset();
    leds_in = 8'hFF;
    wr(2'd0, 32'h3);
    wr(2'd2, 32'd10);
    repeat (7) cycle();
    wr(2'd2, 32'd4);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("blink4", {24'b0, led_pins}, (i < 4) ? 32'hFF : 32'h00);
    end

    // Async reset mid-PWM with LEDs lit
    wr(2'd0, 32'h0);
    cycle();
    check("lit_before_rst", {24'b0, led_pins}, 32'hFF);
    do_reset();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] a;
      if (i == 1000 || i == 2000) do_reset();
      leds_in = 8'($urandom);
      r = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      if (r < 6) begin
        case (a)
          2'd1: wr(a, ($urandom_range(0, 3) == 0) ? 32'hFF : {24'b0, 8'($urandom)});
          2'd2: wr(a, {8'($urandom), 24'($urandom_range(0, 20))});
          default: wr(a, $urandom);
        endcase
      end else if (r < 14) begin
        rd_check(a);
        cycle();
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
